// File: rtl/shift_ser_pkg.sv
// Shared types and constants for the shift_serializer transmitter.
package shift_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out transmitter with frame strobes, MSB- or LSB-first.
// Optional trailing even-parity bit when SHIFT_SER_PARITY_EN is defined.
module shift_serializer
  import shift_ser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dir,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  ser_state_t       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic             last_bit;
  logic             accept;
`ifdef SHIFT_SER_PARITY_EN
  logic             parity_q;
`endif

  assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
  assign accept   = in_valid && in_ready;

  // in_ready decodes from registered state only, never from in_* inputs.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:   in_ready = 1'b1;
`ifdef SHIFT_SER_PARITY_EN
      PARITY: in_ready = 1'b1;
`else
      SHIFT:  in_ready = (cnt_q == '0);
`endif
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_MSB_FIRST;
`ifdef SHIFT_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (accept) begin
      // Any accepting state reloads, which gives zero-gap back-to-back frames.
      state_q  <= SHIFT;
      shreg_q  <= in_data;
      cnt_q    <= CNT_MAX;
      dir_q    <= dir;
`ifdef SHIFT_SER_PARITY_EN
      parity_q <= ^in_data;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          shreg_q <= (dir_q == DIR_LSB_FIRST) ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
`ifdef SHIFT_SER_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= IDLE;
`endif
          end
        end
        PARITY:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    case (state_q)
      SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = (dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];
        frame_start  = (cnt_q == CNT_MAX);
`ifndef SHIFT_SER_PARITY_EN
        frame_end    = last_bit;
`endif
      end
`ifdef SHIFT_SER_PARITY_EN
      PARITY: begin
        serial_valid = 1'b1;
        serial_out   = parity_q;
        frame_end    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
